// File: rtl/core_pipe_fetch_align_pkg.sv
// Shared constants and helpers for the fetch aligner: instruction/halfword
// widths, halfword-count encoding and the RVC length test.
package core_pipe_fetch_align_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned HW      = 16;
  localparam int unsigned FETCH_W = 32;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2
  } hw_cnt_e;

  // Low two bits 2'b11 mark a 32-bit instruction; anything else is RVC.
  function automatic logic is_len32(input logic [HW-1:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/core_pipe_fetch_align_buf.sv
// Halfword shift buffer: slot 0 is oldest. Supports pop of 0..2 and push of
// 0..2 halfwords in the same cycle, plus a clear that overrides both.
module core_pipe_fetch_align_buf
  import core_pipe_fetch_align_pkg::*;
#(
  parameter int unsigned BUF_HW = 4,
  parameter int unsigned CW     = $clog2(BUF_HW + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [1:0]    pop_i,
  input  logic [1:0]    push_i,
  input  logic [31:0]   push_hw_i,
  input  logic          push_err_i,
  output logic [15:0]   slot0_o,
  output logic [15:0]   slot1_o,
  output logic          err0_o,
  output logic          err1_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned IW = $clog2(BUF_HW);

  logic [HW-1:0]     hw_q [BUF_HW];
  logic [HW-1:0]     hw_d [BUF_HW];
  logic [BUF_HW-1:0] err_q, err_d;
  logic [CW-1:0]     count_q, count_d;
  int unsigned       base;
  int unsigned       src;

  // Shift by the pop amount first, then append behind the surviving entries.
  always_comb begin
    base    = 32'(count_q) - 32'(pop_i);
    count_d = CW'(base + 32'(push_i));
    src     = 0;
    err_d   = '0;
    for (int unsigned i = 0; i < BUF_HW; i++) begin
      src = i + 32'(pop_i);
      if (src < BUF_HW) begin
        hw_d[IW'(i)]  = hw_q[src[IW-1:0]];
        err_d[IW'(i)] = err_q[src[IW-1:0]];
      end else begin
        hw_d[IW'(i)]  = '0;
        err_d[IW'(i)] = 1'b0;
      end
      if (push_i != 2'd0 && i == base) begin
        hw_d[IW'(i)]  = push_hw_i[15:0];
        err_d[IW'(i)] = push_err_i;
      end
      if (push_i == 2'd2 && i == base + 1) begin
        hw_d[IW'(i)]  = push_hw_i[31:16];
        err_d[IW'(i)] = push_err_i;
      end
    end
    if (clr_i) begin
      for (int unsigned i = 0; i < BUF_HW; i++) begin
        hw_d[IW'(i)] = '0;
      end
      err_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BUF_HW; i++) begin
        hw_q[IW'(i)] <= '0;
      end
      err_q   <= '0;
      count_q <= '0;
    end else begin
      hw_q    <= hw_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign slot0_o = hw_q[0];
  assign slot1_o = hw_q[1];
  assign err0_o  = err_q[0];
  assign err1_o  = err_q[1];
  assign count_o = count_q;

endmodule

// File: rtl/core_pipe_fetch_align.sv
// Fetch aligner: re-slices 32-bit fetch words into whole RVC / 32-bit
// instructions for decode. Holds pc, halfword-drop state and handshakes.
module core_pipe_fetch_align
  import core_pipe_fetch_align_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned BUF_HW = 4   // 4..8, even
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [31:0]     f_data,
  input  logic            f_error,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [31:0]     d_instr,
  output logic            d_size,
  output logic [XLEN-1:0] d_pc,
  output logic            d_error
);

  localparam int unsigned CW = $clog2(BUF_HW + 1);

  logic [CW-1:0]      count;
  logic [HW-1:0]      slot0, slot1;
  logic               err0, err1;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               drop_q, drop_d;
  hw_cnt_e            pop_n, push_n;
  logic               len32, inst_ok, consume, fill;
  logic [FETCH_W-1:0] push_data;

  always_comb begin
    len32   = is_len32(slot0);
    inst_ok = (count != '0) && (err0 || !len32 || count >= CW'(2));
    d_valid = inst_ok && !flush;
    // An errored head is always emitted alone as a zeroed 16-bit instruction.
    d_size  = len32 && !err0;
    d_error = err0 || (d_size && err1);
    if (err0) begin
      d_instr = '0;
    end else if (len32) begin
      d_instr = {slot1, slot0};
    end else begin
      d_instr = {HW'(0), slot0};
    end
    d_pc    = pc_q;

    consume = d_valid && d_ready;
    pop_n   = HW_NONE;
    if (consume) begin
      pop_n = d_size ? HW_TWO : HW_ONE;
    end

    f_ready   = !flush && ((32'(count) - 32'(pop_n)) <= (BUF_HW - 2));
    fill      = f_valid && f_ready;
    push_n    = HW_NONE;
    if (fill) begin
      push_n = drop_q ? HW_ONE : HW_TWO;
    end
    push_data = drop_q ? {HW'(0), f_data[31:16]} : f_data;

    pc_d   = pc_q;
    drop_d = drop_q;
    if (flush) begin
      pc_d   = {flush_pc[XLEN-1:1], 1'b0};
      drop_d = flush_pc[1];
    end else begin
      if (consume) begin
        pc_d = pc_q + (d_size ? XLEN'(4) : XLEN'(2));
      end
      if (fill && drop_q) begin
        drop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      pc_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  core_pipe_fetch_align_buf #(
    .BUF_HW (BUF_HW)
  ) u_buf (
    .clk_i      (g_clk),
    .rst_ni     (g_resetn),
    .clr_i      (flush),
    .pop_i      (pop_n),
    .push_i     (push_n),
    .push_hw_i  (push_data),
    .push_err_i (f_error),
    .slot0_o    (slot0),
    .slot1_o    (slot1),
    .err0_o     (err0),
    .err1_o     (err1),
    .count_o    (count)
  );

endmodule

// File: tb/tb_core_pipe_fetch_align.sv
// Directed bench for core_pipe_fetch_align: vector table plus hand-written
// backpressure and mid-stream reset sequences.
module tb_core_pipe_fetch_align;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned BUF_HW = 4;
  localparam int          NV     = 33;

  logic            g_clk = 1'b0;
  logic            g_resetn, flush, f_valid, f_error, d_ready;
  logic            f_ready, d_valid, d_size, d_error;
  logic [XLEN-1:0] flush_pc, d_pc;
  logic [31:0]     f_data, d_instr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_fetch_align #(
    .XLEN   (XLEN),
    .BUF_HW (BUF_HW)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (flush),
    .flush_pc (flush_pc),
    .f_valid  (f_valid),
    .f_ready  (f_ready),
    .f_data   (f_data),
    .f_error  (f_error),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_instr  (d_instr),
    .d_size   (d_size),
    .d_pc     (d_pc),
    .d_error  (d_error)
  );

  typedef struct {
    logic        fl;
    logic [63:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        dr;
    logic        edv;
    logic        efr;
    logic [31:0] ei;
    logic        es;
    logic [63:0] epc;
    logic        ee;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic fl, logic [63:0] fpc, logic fv, logic [31:0] fd,
                              logic fe, logic dr, logic edv, logic efr,
                              logic [31:0] ei, logic es, logic [63:0] epc, logic ee);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.fe = fe; v.dr = dr;
    v.edv = edv; v.efr = efr; v.ei = ei; v.es = es; v.epc = epc; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [63:0] fpc, input logic fv,
                       input logic [31:0] fd, input logic fe, input logic dr);
    flush = fl; flush_pc = fpc; f_valid = fv; f_data = fd; f_error = fe; d_ready = dr;
  endtask

  logic [31:0] words [5];
  logic [15:0] exph  [10];
  logic        stall_fr [4];
  int          widx, oidx;

  initial begin
    //           fl fpc      fv fdata         fe dr  dv fr instr         sz pc       er
    vecs[0]  = mk(1, 64'h0,   0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 64'h0,   0);
    vecs[1]  = mk(0, 64'h0,   1, 32'h00010001, 0, 1,  0, 1, 32'h0,        0, 64'h0,   0);
    vecs[2]  = mk(0, 64'h0,   1, 32'h00020002, 0, 1,  1, 1, 32'h00000001, 0, 64'h0,   0);
    vecs[3]  = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000001, 0, 64'h2,   0);
    vecs[4]  = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000002, 0, 64'h4,   0);
    vecs[5]  = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000002, 0, 64'h6,   0);
    vecs[6]  = mk(0, 64'h0,   0, 32'h0,        0, 1,  0, 1, 32'h0,        0, 64'h8,   0);
    vecs[7]  = mk(1, 64'h103, 1, 32'hDEADBEEF, 0, 1,  0, 0, 32'h0,        0, 64'h8,   0);
    vecs[8]  = mk(0, 64'h0,   1, 32'h00120001, 0, 1,  0, 1, 32'h0,        0, 64'h102, 0);
    vecs[9]  = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000012, 0, 64'h102, 0);
    vecs[10] = mk(1, 64'h106, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 64'h104, 0);
    vecs[11] = mk(0, 64'h0,   1, 32'h00130001, 0, 1,  0, 1, 32'h0,        0, 64'h106, 0);
    vecs[12] = mk(0, 64'h0,   1, 32'hABCD5678, 0, 1,  0, 1, 32'h0,        0, 64'h106, 0);
    vecs[13] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h56780013, 1, 64'h106, 0);
    vecs[14] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h0000ABCD, 0, 64'h10A, 0);
    vecs[15] = mk(1, 64'h0,   0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 64'h10C, 0);
    vecs[16] = mk(0, 64'h0,   1, 32'h00130001, 0, 1,  0, 1, 32'h0,        0, 64'h0,   0);
    vecs[17] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000001, 0, 64'h0,   0);
    vecs[18] = mk(0, 64'h0,   0, 32'h0,        0, 1,  0, 1, 32'h0,        0, 64'h2,   0);
    vecs[19] = mk(0, 64'h0,   1, 32'h12340000, 0, 1,  0, 1, 32'h0,        0, 64'h2,   0);
    vecs[20] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000013, 1, 64'h2,   0);
    vecs[21] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00001234, 0, 64'h6,   0);
    vecs[22] = mk(1, 64'h0,   0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 64'h8,   0);
    vecs[23] = mk(0, 64'h0,   1, 32'h00130001, 0, 0,  0, 1, 32'h0,        0, 64'h0,   0);
    vecs[24] = mk(0, 64'h0,   1, 32'h55570000, 1, 0,  1, 1, 32'h00000001, 0, 64'h0,   0);
    vecs[25] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 0, 32'h00000001, 0, 64'h0,   0);
    vecs[26] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000013, 1, 64'h2,   1);
    vecs[27] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h0,        0, 64'h6,   1);
    vecs[28] = mk(0, 64'h0,   1, 32'h00020001, 0, 0,  0, 1, 32'h0,        0, 64'h8,   0);
    vecs[29] = mk(1, 64'h200, 1, 32'h00030003, 0, 1,  0, 0, 32'h0,        0, 64'h8,   0);
    vecs[30] = mk(0, 64'h0,   0, 32'h0,        0, 1,  0, 1, 32'h0,        0, 64'h200, 0);
    vecs[31] = mk(0, 64'h0,   1, 32'h00050004, 0, 1,  0, 1, 32'h0,        0, 64'h200, 0);
    vecs[32] = mk(0, 64'h0,   0, 32'h0,        0, 1,  1, 1, 32'h00000004, 0, 64'h200, 0);

    for (int k = 0; k < 5; k++) begin
      words[k]    = {16'(16'h0105 + 8 * k), 16'(16'h0101 + 8 * k)};
      exph[2*k]   = 16'(16'h0101 + 8 * k);
      exph[2*k+1] = 16'(16'h0105 + 8 * k);
    end
    stall_fr[0] = 1'b1; stall_fr[1] = 1'b1; stall_fr[2] = 1'b0; stall_fr[3] = 1'b0;

    g_resetn = 1'b0;
    drive(0, 64'h0, 0, 32'h0, 0, 0);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("reset d_valid", d_valid, 0);
    chk("reset f_ready", f_ready, 1);
    chk("reset d_instr", d_instr, 0);
    chk("reset d_size",  d_size,  0);
    chk("reset d_pc",    d_pc,    0);
    chk("reset d_error", d_error, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge g_clk);
      drive(vecs[i].fl, vecs[i].fpc, vecs[i].fv, vecs[i].fd, vecs[i].fe, vecs[i].dr);
      #1;
      chk($sformatf("v%0d d_valid", i), d_valid, vecs[i].edv);
      chk($sformatf("v%0d f_ready", i), f_ready, vecs[i].efr);
      chk($sformatf("v%0d d_pc", i),    d_pc,    vecs[i].epc);
      if (vecs[i].edv) begin
        chk($sformatf("v%0d d_instr", i), d_instr, vecs[i].ei);
        chk($sformatf("v%0d d_size", i),  d_size,  vecs[i].es);
        chk($sformatf("v%0d d_error", i), d_error, vecs[i].ee);
      end
    end

    // Backpressure: stall decode with fetch always offering, then drain.
    @(negedge g_clk);
    drive(1, 64'h0, 0, 32'h0, 0, 0);
    widx = 0;
    oidx = 0;
    for (int c = 0; c < 60 && oidx < 10; c++) begin
      @(negedge g_clk);
      drive(0, 64'h0, (widx < 5), words[(widx < 5) ? widx : 0], 0, (c >= 4));
      #1;
      if (c < 4) chk($sformatf("bp stall%0d f_ready", c), f_ready, stall_fr[c]);
      if (d_valid && d_ready) begin
        chk($sformatf("bp out%0d d_instr", oidx), d_instr, {16'h0, exph[oidx]});
        chk($sformatf("bp out%0d d_pc", oidx), d_pc, 64'(2 * oidx));
        oidx++;
      end
      if (f_valid && f_ready) widx++;
    end
    chk("bp instrs emitted", oidx, 10);
    chk("bp words accepted", widx, 5);

    // Mid-stream reset behaves like a flush to pc 0.
    @(negedge g_clk);
    drive(1, 64'h40, 0, 32'h0, 0, 0);
    @(negedge g_clk);
    drive(0, 64'h0, 1, 32'h00070007, 0, 0);
    @(negedge g_clk);
    drive(0, 64'h0, 0, 32'h0, 0, 0);
    #1;
    chk("prerst d_valid", d_valid, 1);
    chk("prerst d_pc", d_pc, 64'h40);
    @(negedge g_clk);
    g_resetn = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("midrst d_valid", d_valid, 0);
    chk("midrst d_pc", d_pc, 0);
    chk("midrst f_ready", f_ready, 1);
    chk("midrst d_instr", d_instr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
